hazard_fwd_ctrl: RTL and testbench

Parametrised successor to the pipeline's data-hazard logic. It combines three functions in one block:
- operand forwarding for `N_SRC` source operands;
- store-data (MEM→MEM) forwarding;
- a sequential load-use stall controller that inserts `LU_BUBBLES` bubbles and freezes the pipe on data-memory wait.

It sits beside the ID/EX boundary. It drives the EX operand muxes, the PC and IF/ID write enables, and the ID/EX bubble injection. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/fwd_mux_sel.sv | 37 +++
 rtl/hazard_fwd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the data-hazard block.
//   stall_state_e : stall controller state encoding
//   FWD_*         : EX operand mux select codes
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StFreeze  = 2'd2
  } stall_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/fwd_mux_sel.sv
// Per-operand forward-select comparator.
//   src           : source register index of one ID/EX operand
//   mem_reg_write : EX/MEM writes the register file
//   mem_dst       : EX/MEM destination register
//   wb_reg_write  : MEM/WB writes the register file
//   wb_dst        : MEM/WB destination register
//   sel           : FWD_EXMEM / FWD_MEMWB / FWD_RF, EX/MEM taking priority
module fwd_mux_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_dst,
  output logic [1:0]       sel
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hard-wired, so a write to it never produces a hazard.
  assign mem_hit = mem_reg_write && (mem_dst != '0) && (mem_dst == src);
  assign wb_hit  = wb_reg_write && (wb_dst != '0) && (wb_dst == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_EXMEM;
    end else if (wb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Data-hazard controller beside the ID/EX boundary.
//   Forwarding (combinational): fwd_sel per EX operand, fwd_m2m for store data.
//   Load-use stall FSM: inserts LU_BUBBLES bubbles via pc_we/ifid_we/idex_bubble
//   and freezes the whole pipe (no bubble) while dmem_wait is high.
//   stall_cycles: saturating count of bubble cycles, cleared by cnt_clr.
// While rst_n is low every combinational output is forced to its idle value.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC*REG_W-1:0] id_src,
  input  logic [N_SRC-1:0]       id_src_used,
  input  logic [N_SRC*REG_W-1:0] ex_src,
  input  logic                   ex_mem_read,
  input  logic [REG_W-1:0]       ex_dst,
  input  logic                   mem_reg_write,
  input  logic [REG_W-1:0]       mem_dst,
  input  logic                   mem_mem_write,
  input  logic [REG_W-1:0]       mem_rt,
  input  logic                   wb_reg_write,
  input  logic [REG_W-1:0]       wb_dst,
  input  logic                   wb_memtoreg,
  input  logic                   dmem_wait,
  input  logic                   id_flush,
  input  logic                   cnt_clr,
  output logic [2*N_SRC-1:0]     fwd_sel,
  output logic                   fwd_m2m,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_bubble,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int unsigned BCNT_W = $clog2(LU_BUBBLES + 1);

  // Forwarding
  logic [2*N_SRC-1:0] fwd_sel_raw;

  for (genvar k = 0; k < N_SRC; k++) begin : g_fwd
    fwd_mux_sel #(
      .REG_W(REG_W)
    ) u_fwd_mux_sel (
      .src          (ex_src[k*REG_W +: REG_W]),
      .mem_reg_write(mem_reg_write),
      .mem_dst      (mem_dst),
      .wb_reg_write (wb_reg_write),
      .wb_dst       (wb_dst),
      .sel          (fwd_sel_raw[2*k +: 2])
    );
  end

  logic fwd_m2m_raw;
  assign fwd_m2m_raw = mem_mem_write && wb_memtoreg && (wb_dst != '0) && (wb_dst == mem_rt);

  // Load-use detection
  logic lu_hit;
  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (id_src_used[k] && (id_src[k*REG_W +: REG_W] == ex_dst)) begin
        lu_hit = 1'b1;
      end
    end
    lu_hit = lu_hit && ex_mem_read && (ex_dst != '0);
  end

  // Stall FSM
  stall_state_e      state_q, state_d;
  stall_state_e      ret_q, ret_d;
  stall_state_e      eff_state;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              flush_eff;
  logic              pc_we_raw;
  logic              bubble_raw;

  // When the memory releases, FREEZE hands the cycle straight to the saved
  // state so the stall window grows by exactly the number of wait cycles.
  assign eff_state = (state_q == StFreeze && !dmem_wait) ? ret_q : state_q;
  // A flush arriving while frozen is not acted upon, even on the release cycle.
  assign flush_eff = id_flush && (state_q != StFreeze);

  always_comb begin
    state_d    = eff_state;
    ret_d      = ret_q;
    bcnt_d     = bcnt_q;
    pc_we_raw  = 1'b1;
    bubble_raw = 1'b0;
    unique case (eff_state)
      StRun: begin
        if (dmem_wait) begin
          pc_we_raw = 1'b0;
          state_d   = StFreeze;
          ret_d     = StRun;
        end else if (lu_hit && !flush_eff) begin
          pc_we_raw  = 1'b0;
          bubble_raw = 1'b1;
          if (LU_BUBBLES > 1) begin
            state_d = StLuStall;
            bcnt_d  = BCNT_W'(LU_BUBBLES - 1);
          end
        end
      end
      StLuStall: begin
        pc_we_raw = 1'b0;
        if (dmem_wait) begin
          state_d = StFreeze;
          ret_d   = StLuStall;
        end else begin
          bubble_raw = 1'b1;
          if (flush_eff) begin
            state_d = StRun;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q - BCNT_W'(1);
            if (bcnt_q == BCNT_W'(1)) begin
              state_d = StRun;
            end
          end
        end
      end
      StFreeze: begin
        pc_we_raw = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ret_q   <= StRun;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Outputs, forced idle during reset
  always_comb begin
    fwd_sel     = '0;
    fwd_m2m     = 1'b0;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    if (rst_n) begin
      fwd_sel     = fwd_sel_raw;
      fwd_m2m     = fwd_m2m_raw;
      pc_we       = pc_we_raw;
      ifid_we     = pc_we_raw;
      idex_bubble = bubble_raw;
    end
  end

  // Stall counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (idex_bubble && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench: three instances (LU_BUBBLES 1/3/4, counter widths 16/4/3)
// share one randomized stimulus stream; a cycle-level model predicts outputs.
module tb_hazard_fwd_ctrl;

  localparam int REG_W = 5;
  localparam int N_SRC = 2;
  localparam int LB [3] = '{1, 3, 4};
  localparam int CMAX [3] = '{65535, 15, 7};

  logic             clk = 1'b0;
  logic             rst_n;
  logic [9:0]       id_src;
  logic [1:0]       id_src_used;
  logic [9:0]       ex_src;
  logic             ex_mem_read;
  logic [4:0]       ex_dst;
  logic             mem_reg_write;
  logic [4:0]       mem_dst;
  logic             mem_mem_write;
  logic [4:0]       mem_rt;
  logic             wb_reg_write;
  logic [4:0]       wb_dst;
  logic             wb_memtoreg;
  logic             dmem_wait;
  logic             id_flush;
  logic             cnt_clr;

  logic [3:0]  fs [3];
  logic        m2m [3];
  logic        pcwe [3];
  logic        ifidwe [3];
  logic        bub [3];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [2:0]  cnt_c;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_W(REG_W), .N_SRC(N_SRC), .LU_BUBBLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .mem_mem_write(mem_mem_write), .mem_rt(mem_rt),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_memtoreg(wb_memtoreg),
    .dmem_wait(dmem_wait), .id_flush(id_flush), .cnt_clr(cnt_clr), .fwd_sel(fs[0]),
    .fwd_m2m(m2m[0]), .pc_we(pcwe[0]), .ifid_we(ifidwe[0]), .idex_bubble(bub[0]),
    .stall_cycles(cnt_a)
  );

  hazard_fwd_ctrl #(.REG_W(REG_W), .N_SRC(N_SRC), .LU_BUBBLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .mem_mem_write(mem_mem_write), .mem_rt(mem_rt),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_memtoreg(wb_memtoreg),
    .dmem_wait(dmem_wait), .id_flush(id_flush), .cnt_clr(cnt_clr), .fwd_sel(fs[1]),
    .fwd_m2m(m2m[1]), .pc_we(pcwe[1]), .ifid_we(ifidwe[1]), .idex_bubble(bub[1]),
    .stall_cycles(cnt_b)
  );

  hazard_fwd_ctrl #(.REG_W(REG_W), .N_SRC(N_SRC), .LU_BUBBLES(4), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .mem_mem_write(mem_mem_write), .mem_rt(mem_rt),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_memtoreg(wb_memtoreg),
    .dmem_wait(dmem_wait), .id_flush(id_flush), .cnt_clr(cnt_clr), .fwd_sel(fs[2]),
    .fwd_m2m(m2m[2]), .pc_we(pcwe[2]), .ifid_we(ifidwe[2]), .idex_bubble(bub[2]),
    .stall_cycles(cnt_c)
  );

  typedef struct packed {
    logic [3:0]       fs;
    logic             m2m;
    logic [2:0]       pcwe;
    logic [2:0]       ifidwe;
    logic [2:0]       bub;
    logic [2:0][15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  // Model state: bubbles still owed, frozen last cycle, counter value.
  int   rem [3];
  bit   frz [3];
  int   mcnt [3];

  function automatic logic [3:0] m_fwd();
    logic [3:0] r;
    logic [4:0] s;
    r = '0;
    for (int k = 0; k < N_SRC; k++) begin
      s = ex_src[k*REG_W +: REG_W];
      if (mem_reg_write && mem_dst != 0 && mem_dst == s) r[2*k +: 2] = 2'b10;
      else if (wb_reg_write && wb_dst != 0 && wb_dst == s) r[2*k +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic logic m_lu();
    logic h;
    h = 1'b0;
    for (int k = 0; k < N_SRC; k++)
      if (id_src_used[k] && id_src[k*REG_W +: REG_W] == ex_dst) h = 1'b1;
    return h && ex_mem_read && ex_dst != 0;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Issue one cycle of stimulus already on the inputs; push its prediction.
  task automatic cyc();
    exp_t e;
    logic lu, fl, pc, bb;
    e  = '0;
    lu = m_lu();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        pc = 1'b1; bb = 1'b0;
        rem[i] = 0; frz[i] = 0; mcnt[i] = 0;
        e.cnt[i] = '0;
      end else begin
        fl = id_flush && !frz[i];
        if (dmem_wait) begin
          pc = 1'b0; bb = 1'b0; frz[i] = 1;
        end else begin
          frz[i] = 0;
          if (rem[i] == 0) begin
            if (lu && !fl) begin
              pc = 1'b0; bb = 1'b1; rem[i] = LB[i] - 1;
            end else begin
              pc = 1'b1; bb = 1'b0;
            end
          end else begin
            pc = 1'b0; bb = 1'b1;
            rem[i] = fl ? 0 : rem[i] - 1;
          end
        end
        e.cnt[i] = 16'(mcnt[i]);
        if (cnt_clr) mcnt[i] = 0;
        else if (bb && mcnt[i] != CMAX[i]) mcnt[i]++;
      end
      e.pcwe[i] = pc; e.ifidwe[i] = pc; e.bub[i] = bb;
    end
    e.fs  = rst_n ? m_fwd() : 4'b0;
    e.m2m = rst_n && mem_mem_write && wb_memtoreg && wb_dst != 0 && wb_dst == mem_rt;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    id_src = '0; id_src_used = '0; ex_src = '0; ex_mem_read = 0; ex_dst = '0;
    mem_reg_write = 0; mem_dst = '0; mem_mem_write = 0; mem_rt = '0;
    wb_reg_write = 0; wb_dst = '0; wb_memtoreg = 0;
    dmem_wait = 0; id_flush = 0; cnt_clr = 0;
  endtask

  task automatic load_use_hit();
    ex_mem_read = 1; ex_dst = 5'd5; id_src = {5'd5, 5'd0}; id_src_used = 2'b10;
  endtask

  // Monitor: compare every cycle the DUTs present outputs.
  initial begin
    exp_t e;
    logic [15:0] ac [3];
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        ac[0] = cnt_a; ac[1] = {12'b0, cnt_b}; ac[2] = {13'b0, cnt_c};
        for (int i = 0; i < 3; i++) begin
          check("fwd_sel", i, 32'(fs[i]), 32'(e.fs));
          check("fwd_m2m", i, 32'(m2m[i]), 32'(e.m2m));
          check("pc_we", i, 32'(pcwe[i]), 32'(e.pcwe[i]));
          check("ifid_we", i, 32'(ifidwe[i]), 32'(e.ifidwe[i]));
          check("idex_bubble", i, 32'(bub[i]), 32'(e.bub[i]));
          check("stall_cycles", i, 32'(ac[i]), 32'(e.cnt[i]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin rem[i] = 0; frz[i] = 0; mcnt[i] = 0; end
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    #2;
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // Forwarding priority
    mem_reg_write = 1; mem_dst = 5'd8; wb_reg_write = 1; wb_dst = 5'd8; ex_src = {5'd3, 5'd8};
    cyc();
    mem_reg_write = 0; cyc();
    ex_src = {5'd3, 5'd0}; cyc();
    idle_inputs();

    // MEM->MEM forwarding
    wb_memtoreg = 1; wb_dst = 5'd9; mem_mem_write = 1; mem_rt = 5'd9; cyc();
    wb_dst = 5'd0; cyc();
    idle_inputs();

    // Load-use, then same hit with operand unused
    load_use_hit(); cyc();
    idle_inputs(); repeat (5) cyc();
    load_use_hit(); id_src_used = 2'b01; cyc();
    idle_inputs(); repeat (5) cyc();

    // Deep stall with a freeze in the second cycle
    cnt_clr = 1; cyc(); cnt_clr = 0;
    load_use_hit(); cyc();
    idle_inputs(); dmem_wait = 1; cyc();
    dmem_wait = 0; repeat (6) cyc();

    // Flush during stall
    cnt_clr = 1; cyc(); cnt_clr = 0;
    load_use_hit(); cyc();
    idle_inputs(); id_flush = 1; cyc();
    id_flush = 0; repeat (6) cyc();

    // Saturation, then clear
    load_use_hit(); repeat (20) cyc();
    cnt_clr = 1; cyc(); cnt_clr = 0;
    idle_inputs(); repeat (5) cyc();

    // Reset pulsed mid-stall
    load_use_hit(); cyc();
    idle_inputs(); rst_n = 0; cyc();
    rst_n = 1; repeat (4) cyc();

    // Randomized traffic with small register indices to provoke hits
    repeat (3000) begin
      id_src        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src_used   = 2'($urandom);
      ex_src        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_mem_read   = 1'($urandom);
      ex_dst        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      mem_dst       = 5'($urandom_range(0, 3));
      mem_mem_write = 1'($urandom);
      mem_rt        = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom);
      wb_dst        = 5'($urandom_range(0, 3));
      wb_memtoreg   = 1'($urandom);
      dmem_wait     = ($urandom_range(0, 5) == 0);
      id_flush      = ($urandom_range(0, 6) == 0);
      cnt_clr       = ($urandom_range(0, 40) == 0);
      rst_n         = ($urandom_range(0, 200) != 0);
      cyc();
    end
    rst_n = 1;
    idle_inputs();

    repeat (4) @(negedge clk);
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
